// File: rtl/display_scan_ctrl_if.sv
// Scan-controller bus: run/hold and digit mask in, digit select, anodes and tick out.
// DISPLAY_SCAN_DIMMING_EN adds the 4-bit brightness input.
interface display_scan_ctrl_if;
    logic       enable;
    logic [3:0] digit_mask;
`ifdef DISPLAY_SCAN_DIMMING_EN
    logic [3:0] brightness;
`endif
    logic [1:0] contador;
    logic [3:0] anodes;
    logic       tick;

`ifdef DISPLAY_SCAN_DIMMING_EN
    modport master (output enable, digit_mask, brightness, input contador, anodes, tick);
    modport slave  (input enable, digit_mask, brightness, output contador, anodes, tick);
`else
    modport master (output enable, digit_mask, input contador, anodes, tick);
    modport slave  (input enable, digit_mask, output contador, anodes, tick);
`endif
endinterface

// File: rtl/display_scan_ctrl.sv
// Refresh controller for a 4-digit multiplexed display: slot prescaler, digit select, guarded
// active-low anodes. DISPLAY_SCAN_DIMMING_EN adds a 16-step brightness duty counter.
module display_scan_ctrl #(
    parameter int unsigned DIV_COUNT    = 100000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic               clk,
    input  logic               reset,
    display_scan_ctrl_if.slave scan
);
    localparam int unsigned   PW   = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] PMax = PW'(DIV_COUNT - 1);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    contador_q, contador_d;
    logic [3:0]    anodes_q, anodes_d;
    logic          last_cycle;
    logic          guard_ok;
    logic          duty_ok;

    assign last_cycle = (p_q == PMax);

    always_comb begin
        p_d        = p_q;
        contador_d = contador_q;
        if (scan.enable) begin
            if (last_cycle) begin
                p_d        = '0;
                contador_d = contador_q + 2'd1;
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    // Guard is judged on the next prescaler value so anodes line up with the slot they show in.
    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            localparam logic [PW-1:0] Guard = PW'(GUARD_CYCLES);
            assign guard_ok = (p_d >= Guard);
        end
    endgenerate

`ifdef DISPLAY_SCAN_DIMMING_EN
    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = scan.enable ? (q_q + 4'd1) : 4'd0;
    end

    assign duty_ok = (q_d <= scan.brightness);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end
`else
    assign duty_ok = 1'b1;
`endif

    always_comb begin
        anodes_d = 4'b1111;
        if (scan.enable && guard_ok && duty_ok && scan.digit_mask[contador_d]) begin
            anodes_d[contador_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q        <= '0;
            contador_q <= 2'd0;
            anodes_q   <= 4'b1111;
        end else begin
            p_q        <= p_d;
            contador_q <= contador_d;
            anodes_q   <= anodes_d;
        end
    end

    assign scan.contador = contador_q;
    assign scan.anodes   = anodes_q;
    assign scan.tick     = scan.enable && last_cycle;
endmodule
